// File: rtl/sram_rsp_slv_pkg.sv
// -----------------------------------------------------------------------------
// sram_rsp_slv_pkg
// Shared types and helpers for the SRAM response slave.
//   rsp_t          : one queued response (error flag + read data)
//   word_addr_bad  : true when a byte address is misaligned or falls outside
//                    the word window [base, base + 4*depth)
// Bus-width and base-address macros normally come from mydefines.v. The
// guarded fallbacks below take effect only when that file has not already
// defined them.
// -----------------------------------------------------------------------------
`ifndef SRAM_ADDR_INDEX
`define SRAM_ADDR_INDEX 32'h8000_0000
`endif
`ifndef MYRISCV_ADDRBUS
`define MYRISCV_ADDRBUS 31:0
`endif
`ifndef MYRISCV_DATABUS
`define MYRISCV_DATABUS 31:0
`endif

package sram_rsp_slv_pkg;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } rsp_t;

   // The offset is taken modulo 2^32, so addresses below base wrap to huge
   // word offsets and are rejected by the range test.
   function automatic logic word_addr_bad(input logic [31:0]  addr,
                                          input logic [31:0]  base,
                                          input int unsigned  depth);
      logic [31:0] off;
      off = addr - base;
      word_addr_bad = (addr[1:0] != 2'b00) || ((off >> 2) >= depth);
   endfunction

endpackage

// File: rtl/sram_rsp_slv_rsp_fifo2.sv
// -----------------------------------------------------------------------------
// rsp_fifo2
// Two-entry response queue with simultaneous push/pop.
//   clk, rst     : clock, asynchronous active-low reset (clears pointers/occ)
//   push/push_rsp: enqueue one response
//   pop          : dequeue head (only meaningful when !empty)
//   head_rsp     : oldest entry
//   empty, occ   : occupancy status (0..2)
// -----------------------------------------------------------------------------
module rsp_fifo2
   import sram_rsp_slv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  rsp_t       push_rsp,
   input  logic       pop,
   output rsp_t       head_rsp,
   output logic       empty,
   output logic [1:0] occ
);

   rsp_t slot [2];
   logic wr_ptr;
   logic rd_ptr;

   always_ff @(posedge clk) begin
      if (push) slot[wr_ptr] <= push_rsp;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign head_rsp = slot[rd_ptr];
   assign empty    = (occ == 2'd0);

   // The credit scheme upstream must make these impossible.
   always @(posedge clk) begin
      if (rst) begin
         assert (!(push && occ == 2'd2));
         assert (!(pop && occ == 2'd0));
      end
   end

endmodule

// File: rtl/sram_rsp_slv.sv
// -----------------------------------------------------------------------------
// sram_rsp_slv
// Word-addressed SRAM slave with a valid/ready request channel, an in-order
// valid/ready response channel and a side loader write port.
//   clk, rst              : clock, asynchronous active-low reset
//   sram_req_vld/rdy/addr : fetch request (byte address)
//   sram_rsp_vld/rdy      : response handshake
//   sram_rsp_data/err     : response payload (data forced to 0 on error)
//   ld_we/ld_addr/ld_wdata: loader word write; misaligned or out-of-range
//                           addresses are ignored
// Parameters: DEPTH_WORDS (power of two), BASE_ADDR (byte address of word 0).
// -----------------------------------------------------------------------------
module sram_rsp_slv
   import sram_rsp_slv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = `SRAM_ADDR_INDEX
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sram_req_vld,
   output logic                    sram_req_rdy,
   input  logic [`MYRISCV_ADDRBUS] sram_req_addr,
   output logic [`MYRISCV_DATABUS] sram_rsp_data,
   output logic                    sram_rsp_err,
   output logic                    sram_rsp_vld,
   input  logic                    sram_rsp_rdy,
   input  logic                    ld_we,
   input  logic [`MYRISCV_ADDRBUS] ld_addr,
   input  logic [`MYRISCV_DATABUS] ld_wdata
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [31:0] mem [DEPTH_WORDS];

   logic             accept_p0;
   logic             err_p0;
   logic [IDX_W-1:0] req_idx_p0;
   logic             ld_ok;
   logic [IDX_W-1:0] ld_idx;

   logic             vld_p1;
   logic             err_p1;
   logic [31:0]      rd_data_p1;
   rsp_t             rsp_p1;

   logic             fifo_push;
   logic             fifo_pop;
   rsp_t             fifo_head;
   logic             fifo_empty;
   logic [1:0]       fifo_occ;

   // ---- p0: acceptance, address decode, RAM access ----
   assign accept_p0  = sram_req_vld & sram_req_rdy;
   assign err_p0     = word_addr_bad(sram_req_addr, BASE_ADDR, DEPTH_WORDS);
   assign req_idx_p0 = IDX_W'((sram_req_addr - BASE_ADDR) >> 2);
   assign ld_ok      = ld_we && !word_addr_bad(ld_addr, BASE_ADDR, DEPTH_WORDS);
   assign ld_idx     = IDX_W'((ld_addr - BASE_ADDR) >> 2);

   // Read and write share one edge with non-blocking updates, so a read of
   // the word being loaded returns the old contents.
   always_ff @(posedge clk) begin
      if (ld_ok) mem[ld_idx] <= ld_wdata;
      if (accept_p0 && !err_p0) rd_data_p1 <= mem[req_idx_p0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
      end else begin
         vld_p1 <= accept_p0;
         if (accept_p0) err_p1 <= err_p0;
      end
   end

   // Credits = read in flight + queued responses; built from registers only.
   assign sram_req_rdy = (({1'b0, vld_p1} + fifo_occ) < 2'd2);

   // ---- p1: RAM data valid, bypass or enqueue ----
   always_comb begin
      rsp_p1.err  = err_p1;
      rsp_p1.data = err_p1 ? 32'd0 : rd_data_p1;
   end

   // A fresh response bypasses the queue only when nothing older is waiting
   // and it is consumed right away; otherwise it is queued so that a stalled
   // response stays stable from the queue head.
   always_comb begin
      fifo_pop  = !fifo_empty && sram_rsp_rdy;
      fifo_push = vld_p1 && !(fifo_empty && sram_rsp_rdy);
      if (!fifo_empty) begin
         sram_rsp_vld  = 1'b1;
         sram_rsp_err  = fifo_head.err;
         sram_rsp_data = fifo_head.data;
      end else if (vld_p1) begin
         sram_rsp_vld  = 1'b1;
         sram_rsp_err  = rsp_p1.err;
         sram_rsp_data = rsp_p1.data;
      end else begin
         sram_rsp_vld  = 1'b0;
         sram_rsp_err  = 1'b0;
         sram_rsp_data = 32'd0;
      end
   end

   rsp_fifo2 u_rsp_fifo2 (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_rsp (rsp_p1),
      .pop      (fifo_pop),
      .head_rsp (fifo_head),
      .empty    (fifo_empty),
      .occ      (fifo_occ)
   );

endmodule

// File: tb/tb_sram_rsp_slv.sv
// -----------------------------------------------------------------------------
// tb_sram_rsp_slv
// Self-checking bench for sram_rsp_slv: directed vector table, a reset
// sequence with responses pending, and randomized traffic against a
// transaction-level model (word array + queue of outstanding responses).
// -----------------------------------------------------------------------------
module tb_sram_rsp_slv;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] B     = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        sram_req_vld;
   logic        sram_req_rdy;
   logic [31:0] sram_req_addr;
   logic [31:0] sram_rsp_data;
   logic        sram_rsp_err;
   logic        sram_rsp_vld;
   logic        sram_rsp_rdy;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sram_rsp_slv #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(B)) dut (
      .clk           (clk),
      .rst           (rst),
      .sram_req_vld  (sram_req_vld),
      .sram_req_rdy  (sram_req_rdy),
      .sram_req_addr (sram_req_addr),
      .sram_rsp_data (sram_rsp_data),
      .sram_rsp_err  (sram_rsp_err),
      .sram_rsp_vld  (sram_rsp_vld),
      .sram_rsp_rdy  (sram_rsp_rdy),
      .ld_we         (ld_we),
      .ld_addr       (ld_addr),
      .ld_wdata      (ld_wdata)
   );

   typedef struct {
      logic        lwe;
      logic [31:0] la;
      logic [31:0] lwd;
      logic        rv;
      logic [31:0] ra;
      logic        rr;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] data;
   } exp_t;

   vec_t        tbl [$];
   exp_t        mq  [$];
   logic [31:0] mm  [DEPTH];

   function automatic logic [31:0] w(input int i);
      logic [31:0] v;
      if (i == 0)      v = 32'h1111_1111;
      else if (i == 2) v = 32'h1234_5678;
      else             v = 32'hC0DE_0000 | i;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic lwe, input logic [31:0] la, input logic [31:0] lwd,
                        input logic rv, input logic [31:0] ra, input logic rr);
      @(negedge clk);
      ld_we         = lwe;
      ld_addr       = la;
      ld_wdata      = lwd;
      sram_req_vld  = rv;
      sram_req_addr = ra;
      sram_rsp_rdy  = rr;
      #1;
   endtask

   task automatic row(input logic lwe, input logic [31:0] la, input logic [31:0] lwd,
                      input logic rv, input logic [31:0] ra, input logic rr,
                      input logic er, input logic ev, input logic [31:0] ed, input logic ee);
      tbl.push_back('{lwe, la, lwd, rv, ra, rr, er, ev, ed, ee});
   endtask

   // Model: an address is usable when word aligned and its word offset from
   // the base, taken modulo 2^32, is inside the memory.
   function automatic logic bad(input logic [31:0] a);
      logic [31:0] off;
      off = a - B;
      return (a % 4 != 0) || (off / 4 >= DEPTH);
   endfunction

   function automatic int widx(input logic [31:0] a);
      logic [31:0] off;
      off = (a - B) / 4;
      return int'(off[3:0]);
   endfunction

   task automatic mcyc(input logic lwe, input logic [31:0] la, input logic [31:0] lwd,
                       input logic rv, input logic [31:0] ra, input logic rr);
      logic e_rdy;
      drive(lwe, la, lwd, rv, ra, rr);
      e_rdy = (mq.size() < 2);
      chk("rnd req_rdy", {31'd0, sram_req_rdy}, {31'd0, e_rdy});
      if (mq.size() > 0) begin
         chk("rnd rsp_vld",  {31'd0, sram_rsp_vld}, 32'd1);
         chk("rnd rsp_data", sram_rsp_data, mq[0].data);
         chk("rnd rsp_err",  {31'd0, sram_rsp_err}, {31'd0, mq[0].err});
         if (rr) void'(mq.pop_front());
      end else begin
         chk("rnd rsp_vld",  {31'd0, sram_rsp_vld}, 32'd0);
         chk("rnd rsp_data", sram_rsp_data, 32'd0);
      end
      if (rv && e_rdy) begin
         if (bad(ra)) mq.push_back('{1'b1, 32'd0});
         else         mq.push_back('{1'b0, mm[widx(ra)]});
      end
      if (lwe && !bad(la)) mm[widx(la)] = lwd;
   endtask

   initial begin
      rst           = 1'b0;
      ld_we         = 1'b0;
      ld_addr       = '0;
      ld_wdata      = '0;
      sram_req_vld  = 1'b0;
      sram_req_addr = '0;
      sram_rsp_rdy  = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset rsp_vld",  {31'd0, sram_rsp_vld}, 32'd0);
      chk("reset rsp_err",  {31'd0, sram_rsp_err}, 32'd0);
      chk("reset rsp_data", sram_rsp_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Load words 0..7
      for (int i = 0; i < 8; i++)
         row(1, B + 32'(4*i), w(i), 0, 0, 1,  1, 0, 0, 0);
      // Single read at BASE, latency 1
      row(0, 0, 0, 1, B, 1,  1, 0, 0, 0);
      row(0, 0, 0, 0, 0, 1,  1, 1, w(0), 0);
      // Eight back-to-back reads
      for (int i = 0; i < 8; i++)
         row(0, 0, 0, 1, B + 32'(4*i), 1,  1, (i > 0), (i > 0) ? w(i-1) : 32'd0, 0);
      row(0, 0, 0, 0, 0, 1,  1, 1, w(7), 0);
      row(0, 0, 0, 0, 0, 1,  1, 0, 0, 0);
      // Backpressure: two accepted, third waits, responses held
      row(0, 0, 0, 1, B + 32'h4, 0,  1, 0, 0, 0);
      row(0, 0, 0, 1, B + 32'h8, 0,  1, 1, w(1), 0);
      row(0, 0, 0, 1, B + 32'hC, 0,  0, 1, w(1), 0);
      row(0, 0, 0, 1, B + 32'hC, 0,  0, 1, w(1), 0);
      row(0, 0, 0, 1, B + 32'hC, 1,  0, 1, w(1), 0);
      row(0, 0, 0, 1, B + 32'hC, 1,  1, 1, w(2), 0);
      row(0, 0, 0, 0, 0, 1,  1, 1, w(3), 0);
      row(0, 0, 0, 0, 0, 1,  1, 0, 0, 0);
      // Error responses interleaved with good reads
      row(0, 0, 0, 1, B + 32'h2, 1,  1, 0, 0, 0);
      row(0, 0, 0, 1, B + 32'h4, 1,  1, 1, 0, 1);
      row(0, 0, 0, 1, B + 32'(4*DEPTH), 1,  1, 1, w(1), 0);
      row(0, 0, 0, 1, B + 32'h1C, 1,  1, 1, 0, 1);
      row(0, 0, 0, 1, B - 32'h4, 1,  1, 1, w(7), 0);
      row(0, 0, 0, 0, 0, 1,  1, 1, 0, 1);
      row(0, 0, 0, 0, 0, 1,  1, 0, 0, 0);
      // Read-first on same-cycle load
      row(1, B + 32'h8, 32'hAAAA_5555, 1, B + 32'h8, 1,  1, 0, 0, 0);
      row(0, 0, 0, 1, B + 32'h8, 1,  1, 1, 32'h1234_5678, 0);
      row(0, 0, 0, 0, 0, 1,  1, 1, 32'hAAAA_5555, 0);
      row(0, 0, 0, 0, 0, 1,  1, 0, 0, 0);
      // Loader ignores misaligned and out-of-range addresses
      row(1, B + 32'hE, 32'hDEAD_BEEF, 0, 0, 1,  1, 0, 0, 0);
      row(1, B + 32'(4*DEPTH), 32'hDEAD_BEEF, 1, B + 32'hC, 1,  1, 0, 0, 0);
      row(0, 0, 0, 1, B, 1,  1, 1, w(3), 0);
      row(0, 0, 0, 0, 0, 1,  1, 1, w(0), 0);
      row(0, 0, 0, 0, 0, 1,  1, 0, 0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].lwe, tbl[i].la, tbl[i].lwd, tbl[i].rv, tbl[i].ra, tbl[i].rr);
         chk($sformatf("row%0d req_rdy", i), {31'd0, sram_req_rdy}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("row%0d rsp_vld", i), {31'd0, sram_rsp_vld}, {31'd0, tbl[i].e_vld});
         chk($sformatf("row%0d rsp_data", i), sram_rsp_data, tbl[i].e_data);
         chk($sformatf("row%0d rsp_err", i), {31'd0, sram_rsp_err}, {31'd0, tbl[i].e_err});
      end

      // Reset with two responses pending
      drive(0, 0, 0, 1, B, 0);
      chk("prst rdy0", {31'd0, sram_req_rdy}, 32'd1);
      drive(0, 0, 0, 1, B + 32'h4, 0);
      chk("prst vld1", {31'd0, sram_rsp_vld}, 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      chk("prst rdy2", {31'd0, sram_req_rdy}, 32'd0);
      chk("prst data2", sram_rsp_data, w(0));
      #2 rst = 1'b0;
      #1;
      chk("mid-rst rsp_vld",  {31'd0, sram_rsp_vld}, 32'd0);
      chk("mid-rst rsp_data", sram_rsp_data, 32'd0);
      chk("mid-rst rsp_err",  {31'd0, sram_rsp_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         chk("post-rst req_rdy", {31'd0, sram_req_rdy}, 32'd1);
         chk("post-rst rsp_vld", {31'd0, sram_rsp_vld}, 32'd0);
      end
      drive(0, 0, 0, 1, B, 1);
      chk("post-rst read vld0", {31'd0, sram_rsp_vld}, 32'd0);
      drive(0, 0, 0, 0, 0, 1);
      chk("post-rst read vld1", {31'd0, sram_rsp_vld}, 32'd1);
      chk("post-rst read data", sram_rsp_data, w(0));
      drive(0, 0, 0, 0, 0, 1);
      chk("post-rst read vld2", {31'd0, sram_rsp_vld}, 32'd0);

      // Randomized traffic against the model
      mq.delete();
      for (int i = 0; i < DEPTH; i++)
         mcyc(1, B + 32'(4*i), $urandom, 0, 0, 1);
      for (int c = 0; c < 600; c++) begin
         logic        lwe, rv, rr;
         logic [31:0] la, ra;
         int          sel;
         lwe = ($urandom_range(0, 9) < 3);
         la  = ($urandom_range(0, 9) < 8) ? B + 32'(4*$urandom_range(0, DEPTH-1))
                                          : B + 32'($urandom_range(0, 255));
         rv  = ($urandom_range(0, 9) < 6);
         sel = $urandom_range(0, 19);
         if (sel < 14)      ra = B + 32'(4*$urandom_range(0, DEPTH-1));
         else if (sel < 17) ra = B + 32'($urandom_range(0, 127));
         else               ra = $urandom;
         rr  = ($urandom_range(0, 9) < 6);
         mcyc(lwe, la, $urandom, rv, ra, rr);
      end
      for (int i = 0; i < 4; i++) mcyc(0, 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
